// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, default
// geometry and the header word-count width.
package imem_loader_pkg;

    localparam int unsigned DEFAULT_BASE_ADDR   = 200;
    localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
    localparam int unsigned COUNT_W             = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHdrHi = 3'd1,
        StHdrLo = 3'd2,
        StData  = 3'd3,
        StWrite = 3'd4,
        StChk   = 3'd5,
        StDone  = 3'd6,
        StErr   = 3'd7
    } state_t;

endpackage

// File: rtl/loader_byte_asm.sv
// Assembles four MSB-first stream bytes into a 32-bit word and pulses
// word_ready on the transfer that completes the word.
module loader_byte_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_ready
);

    // Only the three older bytes need storing; the fourth arrives with word_ready.
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= word_next[23:0];
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    always_comb begin
        word_next  = {shift_q, byte_in};
        word_ready = shift_en && (cnt_q == 2'd3);
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a word-count header plus instruction words into instruction memory
// while holding the CPU. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   idx_q;
    logic [COUNT_W-1:0]   idx_inc;
    logic [COUNT_W-1:0]   hdr_count;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          word_next;
    logic                 word_ready;
    logic                 xfer;
    logic                 restart;

    assign xfer      = byte_valid && byte_ready;
    assign restart   = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    assign hdr_count = {count_q[15:8], byte_data};
    assign idx_inc   = idx_q + 1'b1;

    loader_byte_asm u_byte_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart),
        .shift_en   (xfer && (state_q == StData)),
        .byte_in    (byte_data),
        .word_next  (word_next),
        .word_ready (word_ready)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    // Running XOR over header and data bytes; the check byte itself is excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (restart) begin
            csum_q <= '0;
        end else if (xfer && state_q != StChk) begin
            csum_q <= csum_q ^ byte_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StHdrHi;
            end
            StHdrHi: begin
                if (xfer) state_d = StHdrLo;
            end
            StHdrLo: begin
                if (xfer) begin
                    if (hdr_count == '0) begin
                        state_d = StDone;
                    end else if (32'(hdr_count) > DEPTH_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (word_ready) state_d = StWrite;
            end
            StWrite: begin
                if (idx_inc < count_q) begin
                    state_d = StData;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StChk: begin
                if (xfer) state_d = (byte_data == csum_q) ? StDone : StErr;
            end
`endif
            StDone, StErr: begin
                if (start) state_d = StHdrHi;
            end
            default: state_d = StIdle;
        endcase
    end

    // Address and data are captured on the completing byte so WRITE can present them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            if (restart) begin
                count_q <= '0;
                idx_q   <= '0;
            end
            if (state_q == StHdrHi && xfer) count_q[15:8] <= byte_data;
            if (state_q == StHdrLo && xfer) count_q[7:0]  <= byte_data;
            if (word_ready) begin
                addr_q  <= BASE_ADDR + {14'b0, idx_q, 2'b00};
                wdata_q <= word_next;
            end
            if (state_q == StWrite) idx_q <= idx_inc;
        end
    end

    always_comb begin
        byte_ready = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                     (state_q == StData)  || (state_q == StChk);
        imem_we    = (state_q == StWrite);
        imem_addr  = addr_q;
        imem_wdata = wdata_q;
        cpu_hold   = (state_q != StDone);
        done       = (state_q == StDone);
        error      = (state_q == StErr);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a negedge
// monitor pops and compares them. Checksum cases run when IMEM_LOADER_CHECKSUM_EN is set.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'd200;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] csum;
    logic       we_prev = 1'b0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write and last one cycle.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            check("we_width", {31'b0, we_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                         imem_addr, imem_wdata);
            end else begin : pop
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", imem_addr, e.addr);
                check("wr_data", imem_wdata, e.data);
            end
        end
        we_prev <= imem_we && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        ok         = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = byte_ready;
            tick();
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL byte_timeout: byte 0x%02h never accepted, expected acceptance", b);
        end
        csum       = csum ^ b;
        byte_valid = 1'b0;
        byte_data  = 8'hA5;
        repeat (gap) tick();
    endtask

    task automatic send_header(input logic [15:0] n, input int gap);
        csum = 8'h00;
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input int gap);
        exp_q.push_back('{addr: BASE + 32'(idx) * 32'd4, data: w});
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], 0);
        check("we_latency", {31'b0, imem_we}, 32'd1);
        repeat (gap) tick();
    endtask

    task automatic send_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = csum;
        send_byte(c, 0);
`endif
    endtask

    task automatic wait_end(input string name, input logic exp_done, input logic exp_err);
        for (int i = 0; i < 50 && !(done || error); i++) tick();
        check({name, "_done"}, {31'b0, done}, {31'b0, exp_done});
        check({name, "_error"}, {31'b0, error}, {31'b0, exp_err});
        check({name, "_hold"}, {31'b0, cpu_hold}, {31'b0, !exp_done});
        check({name, "_pending"}, exp_q.size(), 32'd0);
    endtask

    task automatic load_two(input string name, input int gap);
        pulse_start();
        send_header(16'd2, gap);
        send_word(32'h20110005, 0, gap);
        send_word(32'h2012000A, 1, gap);
        send_csum();
        wait_end(name, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, {31'b0, byte_ready}, 32'd0);
        check({name, "_we"}, {31'b0, imem_we}, 32'd0);
        check({name, "_addr"}, imem_addr, BASE);
        check({name, "_wdata"}, imem_wdata, 32'd0);
        check({name, "_hold"}, {31'b0, cpu_hold}, 32'd1);
        check({name, "_done"}, {31'b0, done}, 32'd0);
        check({name, "_error"}, {31'b0, error}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        csum       = 8'h00;
        repeat (2) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();
        check("idle_hold", {31'b0, cpu_hold}, 32'd1);

        load_two("n2", 0);

        pulse_start();
        send_header(16'd0, 0);
        wait_end("n0", 1'b1, 1'b0);

        pulse_start();
        send_header(16'd300, 0);
        wait_end("n300", 1'b0, 1'b1);

        load_two("gap7", 7);

        // Abort after the second byte of the first word; nothing may be written.
        pulse_start();
        send_header(16'd2, 0);
        send_byte(8'h20, 0);
        send_byte(8'h11, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        load_two("after_rst", 0);

        // Start pulses mid-word must not disturb index or address.
        pulse_start();
        send_header(16'd2, 0);
        exp_q.push_back('{addr: BASE, data: 32'h20110005});
        send_byte(8'h20, 0);
        pulse_start();
        check("start_ignored", {31'b0, byte_ready}, 32'd1);
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        start = 1'b1;
        send_byte(8'h05, 0);
        start = 1'b0;
        send_word(32'h2012000A, 1, 0);
        send_csum();
        wait_end("start_in_data", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        send_header(16'd1, 0);
        send_word(32'h01020304, 0, 0);
        send_byte(8'h05, 0);
        wait_end("csum_good", 1'b1, 1'b0);

        pulse_start();
        send_header(16'd1, 0);
        send_word(32'h01020304, 0, 0);
        send_byte(8'h06, 0);
        wait_end("csum_bad", 1'b0, 1'b1);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 200, byte address of the first instruction word written.
REQ-002 Parameter DEPTH_WORDS, default 256, maximum number of words accepted per load.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a load.
REQ-006 byte_valid  input  1  source has a stream byte on byte_data.
REQ-007 byte_data  input  8  stream byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  32  instruction-memory byte address.
REQ-011 imem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  freezes PC and pipeline while high.
REQ-013 done  output  1  load completed successfully.
REQ-014 error  output  1  load aborted.

Function
REQ-015 A byte transfers only on a rising edge where byte_valid and byte_ready are both high; byte_data is ignored otherwise.
REQ-016 Stream format: 16-bit word count N, big-endian (HI then LO), followed by N words of 4 bytes each, MSB first.
REQ-017 FSM states: IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR.
REQ-018 byte_ready is high only in HDR_HI, HDR_LO, DATA and CHK, with no combinational dependence on byte_valid.
REQ-019 IDLE, DONE or ERR with start high -> HDR_HI; in DONE/ERR this restart also clears done, error, the word index and the checksum.
REQ-020 Start is ignored in all other states.
REQ-021 HDR_HI -> HDR_LO on transfer; HDR_LO -> DATA on transfer.
REQ-022 From HDR_LO, N=0 goes to DONE and N>DEPTH_WORDS goes to ERR, both without entering DATA.
REQ-023 DATA shifts bytes into a 32-bit assembly register and enters WRITE on the 4th transfer.
REQ-024 WRITE lasts exactly one cycle with imem_we=1, imem_addr=BASE_ADDR+4*idx (32-bit wrap) and imem_wdata=the assembled word.
REQ-025 After WRITE, idx increments; the FSM goes to DATA if idx<N, otherwise to CHK (macro defined) or DONE.
REQ-026 Latency: imem_we is asserted on the cycle immediately after the 4th byte's transfer edge; peak throughput is one word per 5 cycles.
REQ-027 imem_we is low in every state other than WRITE.
REQ-028 imem_addr and imem_wdata hold their last values when imem_we is low.
REQ-029 cpu_hold is high in every state except DONE.
REQ-030 done is high only in DONE; error is high only in ERR.
REQ-031 A byte stall of any length (byte_valid low) in any accepting state causes no state change.

Reset
REQ-032 rst asserted forces IDLE immediately, mid-operation included, and discards any partial word.
REQ-033 Reset output values: byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, error=0.
REQ-034 Reset clears idx, N, the assembly register and the checksum.

Configuration
REQ-035 Macro IMEM_LOADER_CHECKSUM_EN.
REQ-036 With the macro defined, the loader keeps a running XOR of all header and data bytes and, after the last word, expects one extra byte in CHK.
REQ-037 In CHK, a byte equal to the running XOR goes to DONE; any other value goes to ERR.
REQ-038 Without the macro, the CHK state and checksum logic are absent, and the FSM goes from the last WRITE directly to DONE.

Structure
REQ-039 The shared package/include holds the FSM state encodings, the BASE_ADDR/DEPTH_WORDS defaults and the 16-bit count width constant.
REQ-040 The sub-module loader_byte_asm holds the 4-byte shift and byte counter and emits a word_ready pulse; all other logic is inline.

Verification
REQ-041 Load N=2, words 0x20110005, 0x2012000A: writes to address 200 then 204 with that data; done=1 and cpu_hold=0 after the second WRITE.
REQ-042 Header N=0: DONE directly from HDR_LO with zero imem_we pulses; header N=300 (DEPTH_WORDS 256): error=1, no writes.
REQ-043 Insert 7-cycle byte_valid gaps between bytes: the same two writes and values as REQ-041, each imem_we lasting one cycle.
REQ-044 Assert rst after the 2nd byte of word 1: outputs return to reset values at once, and a subsequent start plus full stream loads correctly from address 200.
REQ-045 With IMEM_LOADER_CHECKSUM_EN, N=1, word 0x01020304, checksum byte 0x05 -> done=1; checksum byte 0x06 -> error=1, with the word still written.
REQ-046 Pulse start during DATA: ignored, with no change to idx or address.
